// File: rtl/ising_run_ctrl_if.sv
// Host-side bus of the Ising run controller: weight writes, run request and result handshake.
interface ising_run_ctrl_if #(
  parameter int unsigned N        = 3,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned WEIGHT_W = 3
) ();
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WEIGHT_W-1:0] wr_data;
  logic                wr_err;
  logic                start;
  logic                busy;
  logic                result_valid;
  logic                result_ready;
  logic [N-1:0]        spins;

  modport master (
    output wr_en, wr_addr, wr_data, start, result_ready,
    input  wr_err, busy, result_valid, spins
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, result_ready,
    output wr_err, busy, result_valid, spins
  );
endinterface

// File: rtl/ising_run_ctrl.sv
// Run sequencer for one core_matrix oscillator array: weight register file, array reset/settle/sample
// sequencing and spin-vector readout over a valid/ready handshake.
module ising_run_ctrl #(
  parameter int unsigned N             = 3,
  parameter int unsigned NUM_WEIGHTS   = 5,
  parameter int unsigned WEIGHT_W      = 3,
  parameter int unsigned ZERO_WEIGHT   = 2,
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned RUN_CYCLES    = 1000,
  parameter int unsigned SAMPLE_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                rstn,
  ising_run_ctrl_if.slave                     bus,
  output logic                                core_rstn,
  output logic [(N*(N-1)/2)*WEIGHT_W-1:0]     core_weights,
  input  logic [N-1:0]                        core_outputs
);

  localparam int unsigned NUM_PAIRS = N * (N - 1) / 2;
  localparam int unsigned WTS_W     = NUM_PAIRS * WEIGHT_W;
  localparam int unsigned CNT_W     = $clog2(SAMPLE_CYCLES + 1);
  localparam int unsigned TMR_MAX   =
    (RUN_CYCLES > RESET_CYCLES) ? ((RUN_CYCLES > SAMPLE_CYCLES) ? RUN_CYCLES : SAMPLE_CYCLES)
                                : ((RESET_CYCLES > SAMPLE_CYCLES) ? RESET_CYCLES : SAMPLE_CYCLES);
  localparam int unsigned TMR_W     = $clog2(TMR_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_RUN    = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [WTS_W-1:0]   weights_q, weights_d;
  logic [N-1:0]       sync1_q, sync2_q;
  logic [CNT_W-1:0]   cnt_q [1:N-1];
  logic [CNT_W-1:0]   cnt_d [1:N-1];
  logic [N-1:0]       spins_q, spins_d;
  logic               wr_err_q, wr_err_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               core_rstn_q, core_rstn_d;
  logic               wr_ok;

  // Next-state, weight update, phase-mismatch counting and registered output decode
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    weights_d   = weights_q;
    cnt_d       = cnt_q;
    spins_d     = spins_q;
    wr_ok       = bus.wr_en && (state_q == S_IDLE)
                  && (32'(bus.wr_addr) < NUM_PAIRS) && (32'(bus.wr_data) < NUM_WEIGHTS);
    wr_err_d    = bus.wr_en && !wr_ok;

    if (wr_ok) begin
      weights_d[int'(bus.wr_addr)*WEIGHT_W +: WEIGHT_W] = bus.wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RESET;
          tmr_d   = '0;
        end
      end
      S_RESET: begin
        if (tmr_q == TMR_W'(RESET_CYCLES - 1)) begin
          state_d = S_RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_RUN: begin
        for (int unsigned i = 1; i < N; i++) cnt_d[i] = '0;
        if (tmr_q == TMR_W'(RUN_CYCLES - 1)) begin
          state_d = S_SAMPLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_SAMPLE: begin
        for (int unsigned i = 1; i < N; i++) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(sync2_q[i] ^ sync2_q[0]);
        end
        if (tmr_q == TMR_W'(SAMPLE_CYCLES - 1)) begin
          state_d = S_DONE;
          tmr_d   = '0;
          // Strict majority of anti-phase cycles; an exact tie reads as in-phase
          for (int unsigned i = 1; i < N; i++) begin
            spins_d[i] = (cnt_d[i] > CNT_W'(SAMPLE_CYCLES / 2));
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_DONE: begin
        if (bus.result_ready) begin
          state_d = S_IDLE;
          spins_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d == S_RESET) || (state_d == S_RUN) || (state_d == S_SAMPLE);
    core_rstn_d = (state_d == S_RUN) || (state_d == S_SAMPLE);
    valid_d     = (state_d == S_DONE);
  end

  // State and output registers; synchronous reset abandons any run in progress
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      weights_q   <= {NUM_PAIRS{WEIGHT_W'(ZERO_WEIGHT)}};
      sync1_q     <= '0;
      sync2_q     <= '0;
      for (int unsigned i = 1; i < N; i++) cnt_q[i] <= '0;
      spins_q     <= '0;
      wr_err_q    <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      core_rstn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      weights_q   <= weights_d;
      sync1_q     <= core_outputs;
      sync2_q     <= sync1_q;
      for (int unsigned i = 1; i < N; i++) cnt_q[i] <= cnt_d[i];
      spins_q     <= spins_d;
      wr_err_q    <= wr_err_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      core_rstn_q <= core_rstn_d;
    end
  end

  assign bus.wr_err       = wr_err_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.spins        = spins_q;
  assign core_rstn        = core_rstn_q;
  assign core_weights     = weights_q;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Scoreboard bench for ising_run_ctrl: a stubbed oscillator array drives random/structured phase patterns,
// expected spins and result cycle are computed at start time and checked by an independent monitor.
module tb_ising_run_ctrl;

  localparam int R        = 16;
  localparam int RUNC     = 1000;
  localparam int SMP      = 64;
  localparam int DONE_OFF = R + RUNC + SMP;
  localparam int WIN0     = R + RUNC - 1;
  localparam logic [8:0] ZERO_W = 9'b010_010_010;

  logic       clk = 1'b0;
  logic       rstn;
  logic       core_rstn;
  logic [8:0] core_weights;
  logic [2:0] core_outputs;

  ising_run_ctrl_if #(.N(3), .ADDR_W(2), .WEIGHT_W(3)) bus ();

  ising_run_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .core_rstn    (core_rstn),
    .core_weights (core_weights),
    .core_outputs (core_outputs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         vedge;
    logic [2:0] spins;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] win [64];
  int         run_t  = -1;
  bit         chk_en = 1'b0;
  logic [8:0] exp_w;
  int         n_pass = 0;
  int         n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
  endtask

  // Oscillator stub: structured pattern inside the sampling window, random phases elsewhere
  initial begin
    int k;
    core_outputs = 3'b000;
    forever begin
      @(negedge clk);
      k = cyc + 1 - run_t;
      if (run_t >= 0 && k >= WIN0 && k < WIN0 + SMP) core_outputs = win[k - WIN0];
      else core_outputs = 3'($urandom);
    end
  end

  // Monitor: per-cycle busy/core_rstn profile and scoreboard compare on result_valid
  initial begin
    int         off;
    bit         eb, er, vseen;
    logic [2:0] held;
    exp_t       e;
    vseen = 1'b0;
    held  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (chk_en && rstn) begin
        off = cyc - run_t;
        eb  = (run_t >= 0) && (off >= 0) && (off < DONE_OFF);
        er  = (run_t >= 0) && (off >= R) && (off < DONE_OFF);
        check("busy", 32'(bus.busy), 32'(eb));
        check("core_rstn", 32'(core_rstn), 32'(er));
        if (bus.result_valid) begin
          if (!vseen) begin
            vseen = 1'b1;
            held  = bus.spins;
            if (sb.size() == 0) check("unexpected_valid", 32'(1), 32'(0));
            else begin
              e = sb.pop_front();
              check("valid_cycle", 32'(cyc), 32'(e.vedge));
              check("spins", 32'(bus.spins), 32'(e.spins));
            end
          end else begin
            check("spins_stable", 32'(bus.spins), 32'(held));
          end
        end else begin
          vseen = 1'b0;
        end
      end
    end
  end

  task automatic do_write(input int addr, input int data);
    bit err;
    err = !(addr < 3 && data < 5);
    if (!err) exp_w[addr*3 +: 3] = 3'(data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'(addr);
    bus.wr_data = 3'(data);
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("wr_err", 32'(bus.wr_err), 32'(err));
    check("weights", 32'(core_weights), 32'(exp_w));
    @(negedge clk);
    check("wr_err_pulse", 32'(bus.wr_err), 32'(0));
  endtask

  task automatic do_run(input int mode, input bit disturb, input int ready_delay,
                        input bit with_write, input bit rst_mid, input bit ready_start);
    int         c1, c2, w, a, d;
    logic       b0;
    logic [2:0] es;
    exp_t       e;
    c1 = 0;
    c2 = 0;
    for (int k = 0; k < SMP; k++) begin
      b0 = 1'($urandom);
      case (mode)
        0:       win[k] = {~b0, b0, b0};
        1:       win[k] = {b0 ^ (k % 2 == 1), b0 ^ (k < 33), b0};
        3:       win[k] = {b0 ^ (k % 2 == 0 && k < 62), b0 ^ (k >= 31), b0};
        default: win[k] = 3'($urandom);
      endcase
      if (win[k][1] != win[k][0]) c1++;
      if (win[k][2] != win[k][0]) c2++;
    end
    es = {c2 > SMP / 2, c1 > SMP / 2, 1'b0};

    @(negedge clk);
    bus.start = 1'b1;
    if (with_write) begin
      a = $urandom_range(0, 2);
      d = $urandom_range(0, 4);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'(a);
      bus.wr_data = 3'(d);
      exp_w[a*3 +: 3] = 3'(d);
    end
    run_t   = cyc + 1;
    e.vedge = run_t + DONE_OFF;
    e.spins = es;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    if (with_write) check("weights_with_start", 32'(core_weights), 32'(exp_w));

    if (disturb) begin
      while (cyc + 1 - run_t < 500) @(negedge clk);
      bus.start   = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'd1;
      bus.wr_data = 3'd3;
      @(negedge clk);
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      check("wr_err_busy", 32'(bus.wr_err), 32'(1));
      check("weights_busy", 32'(core_weights), 32'(exp_w));
      @(negedge clk);
      check("wr_err_busy_pulse", 32'(bus.wr_err), 32'(0));
    end

    if (rst_mid) begin
      while (cyc + 1 - run_t < 1040) @(negedge clk);
      chk_en = 1'b0;
      rstn   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midrst_core_rstn", 32'(core_rstn), 32'(0));
      check("midrst_busy", 32'(bus.busy), 32'(0));
      check("midrst_valid", 32'(bus.result_valid), 32'(0));
      check("midrst_weights", 32'(core_weights), 32'(ZERO_W));
      exp_w = ZERO_W;
      sb.delete();
      run_t  = -1;
      rstn   = 1'b1;
      chk_en = 1'b1;
      repeat (100) @(negedge clk);
      check("midrst_valid_after", 32'(bus.result_valid), 32'(0));
      return;
    end

    w = 0;
    while (!bus.result_valid && w < 1500) begin
      @(negedge clk);
      w++;
    end
    if (!bus.result_valid) begin
      check("result_timeout", 32'(0), 32'(1));
      sb.delete();
      run_t = -1;
      return;
    end
    repeat (ready_delay) @(negedge clk);
    bus.result_ready = 1'b1;
    if (ready_start) bus.start = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    bus.start        = 1'b0;
    check("valid_cleared", 32'(bus.result_valid), 32'(0));
    check("spins_cleared", 32'(bus.spins), 32'(0));
    check("idle_after_accept", 32'(bus.busy), 32'(0));
    run_t = -1;
  endtask

  initial begin
    rstn             = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.start        = 1'b0;
    bus.result_ready = 1'b0;
    exp_w            = ZERO_W;
    @(negedge clk);
    @(negedge clk);
    check("rst_weights", 32'(core_weights), 32'(ZERO_W));
    check("rst_core_rstn", 32'(core_rstn), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_valid", 32'(bus.result_valid), 32'(0));
    check("rst_spins", 32'(bus.spins), 32'(0));
    check("rst_wr_err", 32'(bus.wr_err), 32'(0));
    rstn   = 1'b1;
    chk_en = 1'b1;

    do_write(0, 4);
    do_write(1, 2);
    do_write(2, 0);
    check("weights_t2", 32'(core_weights), 32'(9'b000_010_100));
    do_write(3, 1);
    do_write(1, 5);
    for (int i = 0; i < 6; i++) do_write($urandom_range(0, 3), $urandom_range(0, 7));

    do_run(0, 1'b0, 5,  1'b0, 1'b0, 1'b0);
    do_run(1, 1'b1, 50, 1'b0, 1'b0, 1'b0);
    do_run(2, 1'b0, 0,  1'b1, 1'b0, 1'b1);
    do_run(3, 1'b0, 3,  1'b0, 1'b0, 1'b0);
    do_run(2, 1'b0, 7,  1'b0, 1'b0, 1'b0);
    do_run(2, 1'b0, 0,  1'b0, 1'b1, 1'b0);
    do_run(2, 1'b0, 2,  1'b0, 1'b0, 1'b0);
    check("sb_drained", 32'(sb.size()), 32'(0));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
